led_frame_sequencer: RTL and testbench

Sequences the 120-bit LED shift register and converts its serial output into the single-wire one-wire LED waveform. On a start request, or automatically when so configured, it loads the register and emits one timed pulse per bit, rotating the register after each bit. It sends 24 bits per configured module (1–5 modules), then holds the line low for the latch/reset interval. The block sits between the shift register (`LoadRegister`, `RotateRegisterLeft`, `CurrentBit`) and the LED data pin.

---
 rtl/led_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_led_frame_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_sequencer.sv
// Sequences the 120-bit LED shift register and drives the one-wire LED data line.
// Define LED_AUTO_REFRESH_EN to restart frames automatically after each latch interval.
module led_frame_sequencer #(
  parameter int BIT_CYC   = 125,
  parameter int T0H_CYC   = 40,
  parameter int T1H_CYC   = 80,
  parameter int RESET_CYC = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Start,
  input  logic [2:0] NumLEDs,
  input  logic       CurrentBit,
  output logic       LoadRegister,
  output logic       RotateRegisterLeft,
  output logic       DataOut,
  output logic       Busy,
  output logic       FrameDone,
  output logic [1:0] dbg_state_o
);

  localparam int PW = $clog2(BIT_CYC);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_CYC - 1);
  localparam logic [PW-1:0] T0H       = PW'(T0H_CYC);
  localparam logic [PW-1:0] T1H       = PW'(T1H_CYC);
  localparam logic [15:0]   LATCH_LAST = 16'(RESET_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    count_q, count_d;
  logic [6:0]    bit_idx_q, bit_idx_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0]   latch_q, latch_d;
  logic          bit_val_q, bit_val_d;
  logic          dout_q, dout_d;

  logic          cur_bit;
  logic [PW-1:0] high_cyc;
  logic [2:0]    count_norm;
  logic [6:0]    last_idx;
  logic          bit_end, frame_end, latch_end;

  // Out-of-range module counts fall back to a single module.
  assign count_norm = (NumLEDs >= 3'd1 && NumLEDs <= 3'd5) ? NumLEDs : 3'd1;
  assign last_idx   = 7'(count_q) * 7'd24 - 7'd1;

  // CurrentBit is only trusted at phase 0; the held copy covers the rest of the bit.
  assign cur_bit   = (phase_q == '0) ? CurrentBit : bit_val_q;
  assign high_cyc  = cur_bit ? T1H : T0H;
  assign bit_end   = (state_q == SEND) && (phase_q == PHASE_LAST);
  assign frame_end = bit_end && (bit_idx_q == last_idx);
  assign latch_end = (state_q == LATCH) && (latch_q == LATCH_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= 3'd1;
      bit_idx_q <= '0;
      phase_q   <= '0;
      latch_q   <= '0;
      bit_val_q <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      phase_q   <= phase_d;
      latch_q   <= latch_d;
      bit_val_q <= bit_val_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    phase_d   = phase_q;
    latch_d   = latch_q;
    bit_val_d = bit_val_q;
    dout_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = LOAD;
      end
      LOAD: begin
        bit_idx_d = '0;
        phase_d   = '0;
        latch_d   = '0;
        state_d   = SEND;
      end
      SEND: begin
        bit_val_d = cur_bit;
        dout_d    = (phase_q < high_cyc);
        if (bit_end) begin
          phase_d   = '0;
          bit_idx_d = bit_idx_q + 7'd1;
          if (frame_end) state_d = LATCH;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      LATCH: begin
        if (latch_end) begin
          latch_d = '0;
`ifdef LED_AUTO_REFRESH_EN
          state_d = LOAD;
`else
          state_d = IDLE;
`endif
        end else begin
          latch_d = latch_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The module count is sampled only on entry to LOAD and held for the frame.
    if (state_d == LOAD && state_q != LOAD) count_d = count_norm;
  end

  always_comb begin
    LoadRegister       = (state_q == LOAD);
    RotateRegisterLeft = bit_end;
    Busy               = (state_q != IDLE);
    FrameDone          = latch_end;
    DataOut            = dout_q;
    dbg_state_o        = state_q;
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed and randomized frames against a pulse-level reference of the LED waveform.
// Expected pulse widths come straight from the loaded value and the bit-timing rules.
module tb_led_frame_sequencer;

  localparam int BIT = 10;
  localparam int T0  = 3;
  localparam int T1  = 7;
  localparam int RST = 20;
`ifdef LED_AUTO_REFRESH_EN
  localparam int  B2B_GAP = 1;
  localparam logic AUTO   = 1'b1;
`else
  localparam int  B2B_GAP = 2;
  localparam logic AUTO   = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       Start;
  logic [2:0] NumLEDs;
  logic       CurrentBit;
  logic       LoadRegister, RotateRegisterLeft, DataOut, Busy, FrameDone;
  logic [1:0] dbg_state;

  led_frame_sequencer #(
    .BIT_CYC(BIT), .T0H_CYC(T0), .T1H_CYC(T1), .RESET_CYC(RST)
  ) dut (
    .clk(clk), .reset(reset), .Start(Start), .NumLEDs(NumLEDs),
    .CurrentBit(CurrentBit), .LoadRegister(LoadRegister),
    .RotateRegisterLeft(RotateRegisterLeft), .DataOut(DataOut),
    .Busy(Busy), .FrameDone(FrameDone), .dbg_state_o(dbg_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time exceeded, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Behavioural 120-bit shift register on the far side of the strobes.
  logic [119:0] sr;
  logic [119:0] load_val;
  always @(posedge clk) begin
    if (LoadRegister) sr <= load_val;
    else if (RotateRegisterLeft) sr <= {sr[118:0], sr[119]};
  end
  assign CurrentBit = sr[119];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: observed pulse widths against expected widths
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int cyc = 0;
  int hi_len = 0;
  int rot_cnt, done_cnt, load_cnt, load_cyc, done_cyc, first_hi;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset) begin
      hi_len = 0;
    end else begin
      check("ld_rot_excl", {31'b0, LoadRegister & RotateRegisterLeft}, 32'd0);
      if (LoadRegister) begin load_cnt++; load_cyc = cyc; end
      if (RotateRegisterLeft) rot_cnt++;
      if (FrameDone) begin done_cnt++; done_cyc = cyc; end
      if (DataOut) begin
        hi_len++;
        if (first_hi < 0) first_hi = cyc;
      end else if (hi_len != 0) begin
        obs_q.push_back(hi_len);
        hi_len = 0;
      end
    end
  end

  task automatic clear_mon();
    obs_q.delete();
    exp_q.delete();
    rot_cnt = 0; done_cnt = 0; load_cnt = 0; first_hi = -1;
    load_cyc = 0; done_cyc = 0;
  endtask

  // driver: one frame, checked against the reference derived from v and n
  task automatic run_frame(input logic [2:0] n, input logic [119:0] v, input bit disturb);
    int en, nbits, budget, c0;
    en = (n >= 3'd1 && n <= 3'd5) ? int'(n) : 1;
    nbits = 24 * en;
    clear_mon();
    load_val = v;
    for (int i = 0; i < nbits; i++) exp_q.push_back(v[119-i] ? T1 : T0);
    c0 = cyc;
    Start = 1'b1;
    NumLEDs = n;
    @(negedge clk);
    Start = 1'b0;
    check("load_strobe", {31'b0, LoadRegister}, 32'd1);
    check("busy_in_load", {31'b0, Busy}, 32'd1);
    NumLEDs = 3'($urandom_range(0, 7));
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
      if (disturb && budget == 37) begin Start = 1'b1; NumLEDs = 3'd5; end
      if (disturb && budget == 40) Start = 1'b0;
    end
    check("frame_done_seen", {31'b0, done_cnt > 0}, 32'd1);
    check("load_cycle", load_cyc, c0 + 1);
    check("frame_len", done_cyc - load_cyc + 1, 1 + nbits * BIT + RST);
    check("first_rise", first_hi - load_cyc, 32'd2);
    check("rot_cnt", rot_cnt, nbits);
    check("pulse_cnt", obs_q.size(), nbits);
    for (int i = 0; i < nbits; i++)
      check("pulse_w", (i < obs_q.size()) ? obs_q[i] : 32'd0, exp_q[i]);
    check("busy_at_done", {31'b0, Busy}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'b0, Busy}, {31'b0, AUTO});
    repeat (3) @(negedge clk);
    check("single_load", load_cnt, AUTO ? load_cnt : 32'd1);
    check("single_done", done_cnt, 32'd1);
  endtask

  initial begin
    int budget, d;
    logic [119:0] v;
    Start = 1'b0;
    NumLEDs = 3'd1;
    load_val = '0;
    reset = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_load", {31'b0, LoadRegister}, 32'd0);
    check("rst_rot", {31'b0, RotateRegisterLeft}, 32'd0);
    check("rst_dout", {31'b0, DataOut}, 32'd0);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, FrameDone}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", {31'b0, Busy}, 32'd0);

    run_frame(3'd1, {72'hF0F0F0_0F0F0F_0F0F0F, 48'h0}, 1'b0);
    v = {72'hF0F0F0_0F0F0F_0F0F0F, 48'($urandom()) ^ 48'h5A5A_0000_C3C3};
    run_frame(3'd5, v, 1'b0);
    run_frame(3'd0, {72'hF0F0F0_0F0F0F_0F0F0F, 48'h0}, 1'b0);
    run_frame(3'd7, {72'hF0F0F0_0F0F0F_0F0F0F, 48'h0}, 1'b0);
    for (int k = 0; k < 4; k++) begin
      v = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
      run_frame(3'($urandom_range(0, 7)), v, 1'b0);
    end
    v = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
    run_frame(3'd2, v, 1'b1);

    // reset dropped while a pulse is high
    clear_mon();
    load_val = 120'({$urandom(), $urandom(), $urandom(), $urandom()});
    Start = 1'b1;
    NumLEDs = 3'd2;
    @(negedge clk);
    Start = 1'b0;
    repeat (30) @(negedge clk);
    budget = 0;
    while (!DataOut && budget < 50) begin @(negedge clk); budget++; end
    check("rst_mid_high", {31'b0, DataOut}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_dout", {31'b0, DataOut}, 32'd0);
    check("rst_mid_busy", {31'b0, Busy}, 32'd0);
    check("rst_mid_state", {30'b0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (600) @(negedge clk);
    check("rst_no_done", done_cnt, 32'd0);
    check("rst_no_restart", load_cnt, 32'd1);
    check("rst_idle_dout", {31'b0, DataOut}, 32'd0);

    // Start held high continuously
    clear_mon();
    load_val = {72'hF0F0F0_0F0F0F_0F0F0F, 48'h0};
    NumLEDs = 3'd1;
    Start = 1'b1;
    budget = 0;
    while (done_cnt == 0 && budget < 1000) begin @(negedge clk); budget++; end
    check("b2b_done1", {31'b0, done_cnt > 0}, 32'd1);
    d = done_cyc;
    budget = 0;
    while (load_cnt < 2 && budget < 20) begin @(negedge clk); budget++; end
    check("b2b_gap", load_cyc - d, B2B_GAP);
    Start = 1'b0;
    budget = 0;
    while (done_cnt < 2 && budget < 1000) begin @(negedge clk); budget++; end
    check("b2b_done2", done_cnt, 32'd2);
    check("b2b_len", done_cyc - load_cyc + 1, 1 + 24 * BIT + RST);
    repeat (3) @(negedge clk);
    check("b2b_busy_end", {31'b0, Busy}, {31'b0, AUTO});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
